// File: rtl/recorder_pkg.sv
// Shared definitions for the recorder elapsed-time tracker: command codes,
// FSM states, BCD digit type and input-event field positions.
package recorder_pkg;

    localparam logic [3:0] REC_NONE   = 4'd0;
    localparam logic [3:0] REC_RECORD = 4'd1;
    localparam logic [3:0] REC_PAUSE  = 4'd2;
    localparam logic [3:0] REC_STOP   = 4'd3;
    localparam logic [3:0] REC_PLAY   = 4'd4;

    localparam int CMD_MSB   = 15;
    localparam int CMD_LSB   = 12;
    localparam int SPEED_MSB = 11;
    localparam int SPEED_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RECORD     = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4,
        ST_STOP       = 3'd5
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Out-of-range speed requests fall back to real time.
    function automatic logic [3:0] eff_speed(input logic [3:0] field);
        return (field == 4'd0 || field > 4'd8) ? 4'd1 : field;
    endfunction

endpackage

// File: rtl/rec_play_timer_if.sv
// Command/status bundle between the recorder control and the elapsed-time tracker.
interface rec_play_timer_if
    import recorder_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) ();
    localparam int TW = 4 * (MIN_DIGITS + 2);

    logic [15:0]   i_input_event;
    logic [TW-1:0] o_record_time;
    logic [TW-1:0] o_play_time;
    state_t        o_state;
    logic          o_sec_tick;
    logic          o_rec_full;
    logic          o_play_done;

    modport master (
        output i_input_event,
        input  o_record_time, o_play_time, o_state, o_sec_tick, o_rec_full, o_play_done
    );

    modport slave (
        input  i_input_event,
        output o_record_time, o_play_time, o_state, o_sec_tick, o_rec_full, o_play_done
    );
endinterface

// File: rtl/bcd_time_counter.sv
// Packed-BCD mm:ss counter with clear, saturating increment and an
// early flag telling that the next increment lands exactly on max_val.
module bcd_time_counter
    import recorder_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          inc,
    input  logic [4*(MIN_DIGITS+2)-1:0]   max_val,
    output logic [4*(MIN_DIGITS+2)-1:0]   value,
    output logic                          at_max
);
    localparam int TW = 4 * (MIN_DIGITS + 2);
    localparam int ND = MIN_DIGITS + 2;

    logic [TW-1:0] value_inc;
    logic          below_max;

    // Digit 1 is tens-of-seconds and wraps at 5; every other digit wraps at 9.
    function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          carry;
        bcd_digit_t    dig;
        bcd_digit_t    lim;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < ND; d++) begin
            dig = v[4*d +: 4];
            lim = (d == 1) ? 4'd5 : 4'd9;
            if (carry) begin
                if (dig == lim) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = dig + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign value_inc = bcd_inc(value);
    assign below_max = (value != max_val);
    assign at_max    = below_max && (value_inc == max_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && below_max) begin
            value <= value_inc;
        end
    end
endmodule

// File: rtl/rec_play_timer.sv
// Recorder elapsed-time tracker: decodes commands, runs the record/play FSM,
// a speed-scaled one-second prescaler and the play-versus-record compare.
module rec_play_timer
    import recorder_pkg::*;
#(
    parameter int                          CLK_HZ     = 50_000_000,
    parameter int                          MIN_DIGITS = 2,
    parameter logic [4*(MIN_DIGITS+2)-1:0] MAX_BCD    = 16'h5959
) (
    input logic              i_clk,
    input logic              i_rst,
    rec_play_timer_if.slave  bus
);
    localparam int TW = 4 * (MIN_DIGITS + 2);
    localparam int PW = $clog2(CLK_HZ + 9);

    state_t        state, state_nx;
    logic [3:0]    cmd, speed, step;
    logic [PW-1:0] presc, presc_sum;
    logic          run, tick, accept, idle_like, play_like;
    logic          rec_clear, rec_inc, rec_hit;
    logic          play_clear, play_inc, play_hit, speed_ld;
    logic          sec_tick_nx, rec_full_nx, play_done_nx;
    logic          sec_tick_q, rec_full_q, play_done_q;
    logic [TW-1:0] rec_val, play_val;
    logic          unused_bits;

    assign cmd         = bus.i_input_event[CMD_MSB:CMD_LSB];
    assign unused_bits = ^bus.i_input_event[SPEED_LSB-1:0];

    assign run       = (state == ST_RECORD) || (state == ST_PLAY);
    assign step      = (state == ST_PLAY) ? speed : 4'd1;
    assign presc_sum = presc + PW'(step);
    assign tick      = run && (presc_sum >= PW'(CLK_HZ));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Accepted commands always take priority over a same-cycle tick.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE, ST_STOP: begin
                if (cmd == REC_RECORD) begin
                    state_nx = ST_RECORD;
                    accept   = 1'b1;
                end else if (cmd == REC_PLAY) begin
                    state_nx = (rec_val == '0) ? ST_STOP : ST_PLAY;
                    accept   = 1'b1;
                end
            end
            ST_RECORD: begin
                if (cmd == REC_PAUSE) begin
                    state_nx = ST_REC_PAUSE;
                    accept   = 1'b1;
                end else if (cmd == REC_STOP) begin
                    state_nx = ST_STOP;
                    accept   = 1'b1;
                end else if (tick && rec_hit) begin
                    state_nx = ST_STOP;
                end
            end
            ST_REC_PAUSE: begin
                if (cmd == REC_RECORD) begin
                    state_nx = ST_RECORD;
                    accept   = 1'b1;
                end else if (cmd == REC_STOP) begin
                    state_nx = ST_STOP;
                    accept   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (cmd == REC_PAUSE) begin
                    state_nx = ST_PLAY_PAUSE;
                    accept   = 1'b1;
                end else if (cmd == REC_STOP) begin
                    state_nx = ST_STOP;
                    accept   = 1'b1;
                end else if (tick && play_hit) begin
                    state_nx = ST_STOP;
                end
            end
            ST_PLAY_PAUSE: begin
                if (cmd == REC_PLAY) begin
                    state_nx = (play_val >= rec_val) ? ST_STOP : ST_PLAY;
                    accept   = 1'b1;
                end else if (cmd == REC_STOP) begin
                    state_nx = ST_STOP;
                    accept   = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        idle_like    = (state == ST_IDLE) || (state == ST_STOP);
        play_like    = (state == ST_PLAY) || (state == ST_PLAY_PAUSE);
        rec_clear    = accept && idle_like && (cmd == REC_RECORD);
        play_clear   = accept && ((idle_like && (cmd == REC_RECORD || cmd == REC_PLAY)) ||
                                  (play_like && cmd == REC_STOP));
        speed_ld     = accept && (cmd == REC_PLAY);
        rec_inc      = !accept && (state == ST_RECORD) && tick;
        play_inc     = !accept && (state == ST_PLAY) && tick;
        sec_tick_nx  = rec_inc || play_inc;
        rec_full_nx  = rec_inc && rec_hit;
        play_done_nx = (play_inc && play_hit) || (speed_ld && state_nx == ST_STOP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc       <= '0;
            speed       <= 4'd1;
            sec_tick_q  <= 1'b0;
            rec_full_q  <= 1'b0;
            play_done_q <= 1'b0;
        end else begin
            if (accept)    presc <= '0;
            else if (tick) presc <= presc_sum - PW'(CLK_HZ);
            else if (run)  presc <= presc_sum;
            if (speed_ld)  speed <= eff_speed(bus.i_input_event[SPEED_MSB:SPEED_LSB]);
            sec_tick_q  <= sec_tick_nx;
            rec_full_q  <= rec_full_nx;
            play_done_q <= play_done_nx;
        end
    end

    bcd_time_counter #(.MIN_DIGITS(MIN_DIGITS)) u_rec_time (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (rec_clear),
        .inc     (rec_inc),
        .max_val (MAX_BCD),
        .value   (rec_val),
        .at_max  (rec_hit)
    );

    // Play time saturates at, and compares against, the current record length.
    bcd_time_counter #(.MIN_DIGITS(MIN_DIGITS)) u_play_time (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (play_clear),
        .inc     (play_inc),
        .max_val (rec_val),
        .value   (play_val),
        .at_max  (play_hit)
    );

    assign bus.o_record_time = rec_val;
    assign bus.o_play_time   = play_val;
    assign bus.o_state       = state;
    assign bus.o_sec_tick    = sec_tick_q;
    assign bus.o_rec_full    = rec_full_q;
    assign bus.o_play_done   = play_done_q;
endmodule
